// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: channel state encoding and default widths.
package pwm_pkg;

    // Default width of the dead-time counters, in timer clocks.
    localparam int unsigned DefaultDtW = 8;

    // Per-channel gate-drive state.
    typedef enum logic [2:0] {
        StOff,   // both gates low, waiting for enable with no fault
        StLsOn,  // low side on
        StDtR,   // dead time before the high side turns on
        StHsOn,  // high side on
        StDtF    // dead time before the low side turns on
    } ch_state_e;

endpackage

// File: rtl/pwm_deadtime_ch.sv
// One complementary gate-drive channel: state machine, dead-time counter and output registers.
module pwm_deadtime_ch
    import pwm_pkg::*;
#(
    parameter int unsigned DT_W = DefaultDtW
) (
    input  logic            selected_clk,
    input  logic            i_rst,
    input  logic            i_pwm,
    input  logic            i_enable,
    input  logic            i_fault,
    input  logic [DT_W-1:0] i_dt_rise,
    input  logic [DT_W-1:0] i_dt_fall,
    output logic            o_hs,
    output logic            o_ls
);

    localparam logic [DT_W-1:0] CntOne = DT_W'(1);

    ch_state_e       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic [DT_W-1:0] rise_load, fall_load;
    logic            hs_q, ls_q;

    // A programmed dead time of 0 still yields one cycle with both gates low.
    assign rise_load = (i_dt_rise == '0) ? CntOne : i_dt_rise;
    assign fall_load = (i_dt_fall == '0) ? CntOne : i_dt_fall;

    // Next-state and counter logic; disable or fault overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!i_enable || i_fault) begin
            state_d = StOff;
        end else begin
            case (state_q)
                StOff: begin
                    // Always leave through the low side so the bootstrap gets charged.
                    state_d = StLsOn;
                end
                StLsOn: begin
                    if (i_pwm) begin
                        state_d = StDtR;
                        cnt_d   = rise_load;
                    end
                end
                StDtR: begin
                    if (!i_pwm) begin
                        state_d = StLsOn;
                    end else if (cnt_q == CntOne) begin
                        state_d = StHsOn;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StHsOn: begin
                    if (!i_pwm) begin
                        state_d = StDtF;
                        cnt_d   = fall_load;
                    end
                end
                StDtF: begin
                    if (i_pwm) begin
                        state_d = StHsOn;
                    end else if (cnt_q == CntOne) begin
                        state_d = StLsOn;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StOff;
                end
            endcase
        end
    end

    // State, counter and gate registers; gates decode the next state so they move with it.
    always_ff @(posedge selected_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StOff;
            cnt_q   <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hs_q    <= (state_d == StHsOn);
            ls_q    <= (state_d == StLsOn);
        end
    end

    assign o_hs = hs_q;
    assign o_ls = ls_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Multi-channel PWM output stage with dead-time insertion and a latched fault shutdown.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned DT_W        = DefaultDtW,
    parameter int unsigned SYNC_STAGES = 2   // must be at least 2
) (
    input  logic            selected_clk,
    input  logic            i_rst,
    input  logic [NCH-1:0]  i_pwm,
    input  logic            i_enable,
    input  logic [DT_W-1:0] i_dt_rise,
    input  logic [DT_W-1:0] i_dt_fall,
    input  logic            i_fault,
    input  logic            i_fault_clr,
    output logic [NCH-1:0]  o_hs,
    output logic [NCH-1:0]  o_ls,
    output logic            o_fault
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fault_sync;
    logic                   fault_q, fault_d;
    logic                   ch_fault;

    // Synchronizer chain for the asynchronous fault input.
    always_ff @(posedge selected_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_fault};
        end
    end

    assign fault_sync = sync_q[SYNC_STAGES-1];

    // Fault latch: set has priority, clear only takes effect once the fault has gone away.
    always_comb begin
        fault_d = fault_q;
        if (fault_sync) begin
            fault_d = 1'b1;
        end else if (i_fault_clr) begin
            fault_d = 1'b0;
        end
    end

    // Fault latch register.
    always_ff @(posedge selected_clk or posedge i_rst) begin
        if (i_rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    // The raw synchronized fault shuts channels down on the same edge that sets the latch.
    assign ch_fault = fault_sync | fault_q;
    assign o_fault  = fault_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        pwm_deadtime_ch #(
            .DT_W(DT_W)
        ) u_ch (
            .selected_clk(selected_clk),
            .i_rst       (i_rst),
            .i_pwm       (i_pwm[c]),
            .i_enable    (i_enable),
            .i_fault     (ch_fault),
            .i_dt_rise   (i_dt_rise),
            .i_dt_fall   (i_dt_fall),
            .o_hs        (o_hs[c]),
            .o_ls        (o_ls[c])
        );
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: directed vector table, hand sequences, random vs model.
module tb_pwm_deadtime;

    localparam int unsigned NCH         = 4;
    localparam int unsigned DT_W        = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic            selected_clk = 1'b0;
    logic            i_rst;
    logic [NCH-1:0]  i_pwm;
    logic            i_enable;
    logic [DT_W-1:0] i_dt_rise;
    logic [DT_W-1:0] i_dt_fall;
    logic            i_fault;
    logic            i_fault_clr;
    logic [NCH-1:0]  o_hs;
    logic [NCH-1:0]  o_ls;
    logic            o_fault;

    int checks = 0;
    int errors = 0;

    always #5 selected_clk = ~selected_clk;

    pwm_deadtime #(
        .NCH        (NCH),
        .DT_W       (DT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .selected_clk(selected_clk),
        .i_rst       (i_rst),
        .i_pwm       (i_pwm),
        .i_enable    (i_enable),
        .i_dt_rise   (i_dt_rise),
        .i_dt_fall   (i_dt_fall),
        .i_fault     (i_fault),
        .i_fault_clr (i_fault_clr),
        .o_hs        (o_hs),
        .o_ls        (o_ls),
        .o_fault     (o_fault)
    );

    // Directed vector: inputs applied before an edge, outputs expected just after it.
    typedef struct {
        logic [NCH-1:0]  pwm;
        logic            en;
        logic [DT_W-1:0] dr;
        logic [NCH-1:0]  hs;
        logic [NCH-1:0]  ls;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic [NCH-1:0] pwm, input logic en,
                                input logic [DT_W-1:0] dr, input logic [NCH-1:0] hs,
                                input logic [NCH-1:0] ls);
        vec_t v;
        v.pwm = pwm;
        v.en  = en;
        v.dr  = dr;
        v.hs  = hs;
        v.ls  = ls;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [NCH-1:0] hs,
                             input logic [NCH-1:0] ls, input logic f);
        check({tag, " hs"}, 32'(o_hs), 32'(hs));
        check({tag, " ls"}, 32'(o_ls), 32'(ls));
        check({tag, " fault"}, 32'(o_fault), 32'(f));
    endtask

    task automatic tick();
        @(posedge selected_clk);
        #1;
    endtask

    // Behavioural model: each channel has a committed side and a streak counting how long
    // the PWM input has been asking for the other side; the switch happens once the streak
    // has covered the dead time latched when the streak began.
    bit             m_sync[SYNC_STAGES];
    bit             m_lat;
    bit             m_off[NCH];
    bit             m_side[NCH];
    int             m_streak[NCH];
    int             m_need[NCH];
    logic [NCH-1:0] e_hs, e_ls;
    logic           e_fault;

    task automatic model_reset();
        for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b0;
        m_lat = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_off[c]    = 1'b1;
            m_side[c]   = 1'b0;
            m_streak[c] = 0;
            m_need[c]   = 1;
        end
        e_hs    = '0;
        e_ls    = '0;
        e_fault = 1'b0;
    endtask

    task automatic model_edge(input logic [NCH-1:0] pwm, input logic en,
                              input logic [DT_W-1:0] dr, input logic [DT_W-1:0] df,
                              input logic flt, input logic clr);
        bit fs;
        bit kill;
        fs   = m_sync[SYNC_STAGES-1];
        kill = !en || fs || m_lat;
        for (int c = 0; c < NCH; c++) begin
            if (kill) begin
                m_off[c] = 1'b1;
                e_hs[c]  = 1'b0;
                e_ls[c]  = 1'b0;
            end else if (m_off[c]) begin
                m_off[c]    = 1'b0;
                m_side[c]   = 1'b0;
                m_streak[c] = 0;
                e_hs[c]     = 1'b0;
                e_ls[c]     = 1'b1;
            end else if (pwm[c] == m_side[c]) begin
                m_streak[c] = 0;
                e_hs[c]     = m_side[c];
                e_ls[c]     = !m_side[c];
            end else if (m_streak[c] == 0) begin
                m_need[c]   = m_side[c] ? int'(df) : int'(dr);
                if (m_need[c] < 1) m_need[c] = 1;
                m_streak[c] = 1;
                e_hs[c]     = 1'b0;
                e_ls[c]     = 1'b0;
            end else if (m_streak[c] >= m_need[c]) begin
                m_side[c]   = pwm[c];
                m_streak[c] = 0;
                e_hs[c]     = m_side[c];
                e_ls[c]     = !m_side[c];
            end else begin
                m_streak[c]++;
                e_hs[c] = 1'b0;
                e_ls[c] = 1'b0;
            end
        end
        if (fs) m_lat = 1'b1;
        else if (clr) m_lat = 1'b0;
        e_fault = m_lat;
        for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = flt;
    endtask

    initial begin
        logic [NCH-1:0] prev_hs, prev_ls;
        int             fall_cyc[NCH];
        int             fall_need[NCH];
        int             f_hold;

        i_rst       = 1'b1;
        i_pwm       = '0;
        i_enable    = 1'b1;
        i_dt_rise   = 8'd3;
        i_dt_fall   = 8'd0;
        i_fault     = 1'b0;
        i_fault_clr = 1'b0;

        vecs[0]  = mk(4'h0, 1'b1, 8'd3, 4'h0, 4'hF);
        vecs[1]  = mk(4'h0, 1'b1, 8'd3, 4'h0, 4'hF);
        vecs[2]  = mk(4'h1, 1'b1, 8'd3, 4'h0, 4'hE);
        vecs[3]  = mk(4'h1, 1'b1, 8'd3, 4'h0, 4'hE);
        vecs[4]  = mk(4'h1, 1'b1, 8'd3, 4'h0, 4'hE);
        vecs[5]  = mk(4'h1, 1'b1, 8'd3, 4'h1, 4'hE);
        vecs[6]  = mk(4'h3, 1'b1, 8'd3, 4'h1, 4'hC);
        vecs[7]  = mk(4'h3, 1'b1, 8'd3, 4'h1, 4'hC);
        vecs[8]  = mk(4'h3, 1'b1, 8'd3, 4'h1, 4'hC);
        vecs[9]  = mk(4'h3, 1'b1, 8'd3, 4'h3, 4'hC);
        vecs[10] = mk(4'h1, 1'b1, 8'd3, 4'h1, 4'hC);
        vecs[11] = mk(4'h1, 1'b1, 8'd3, 4'h1, 4'hE);
        vecs[12] = mk(4'h1, 1'b1, 8'd3, 4'h1, 4'hE);
        vecs[13] = mk(4'h9, 1'b1, 8'd0, 4'h1, 4'h6);
        vecs[14] = mk(4'h9, 1'b1, 8'd0, 4'h9, 4'h6);
        vecs[15] = mk(4'h9, 1'b0, 8'd0, 4'h0, 4'h0);
        vecs[16] = mk(4'h9, 1'b1, 8'd0, 4'h0, 4'hF);
        vecs[17] = mk(4'h9, 1'b1, 8'd0, 4'h0, 4'h6);
        vecs[18] = mk(4'h9, 1'b1, 8'd0, 4'h9, 4'h6);

        // Reset held across several edges with enable high.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", 4'h0, 4'h0, 1'b0);
        end
        i_rst = 1'b0;

        // Directed table: release, rise with dt=3, fall with dt=0, dt_rise=0, enable drop.
        for (int i = 0; i < 19; i++) begin
            i_pwm     = vecs[i].pwm;
            i_enable  = vecs[i].en;
            i_dt_rise = vecs[i].dr;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].hs, vecs[i].ls, 1'b0);
        end

        // Short pulse on ch2 with a long rise dead time aborts; a mid-count dt change is ignored.
        i_dt_rise = 8'd10;
        i_pwm     = 4'hD;
        tick();
        check_out("abort0", 4'h9, 4'h2, 1'b0);
        i_dt_rise = 8'd1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check_out($sformatf("abort%0d", i), 4'h9, 4'h2, 1'b0);
        end
        i_pwm = 4'h9;
        tick();
        check_out("abort_end", 4'h9, 4'h6, 1'b0);

        // All channels high side on, then fault shutdown and clear handling.
        i_pwm = 4'hF;
        tick();
        check_out("all_dtr", 4'h9, 4'h0, 1'b0);
        tick();
        check_out("all_hs", 4'hF, 4'h0, 1'b0);
        i_fault = 1'b1;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            tick();
            check_out($sformatf("flt_sync%0d", i), 4'hF, 4'h0, 1'b0);
        end
        tick();
        check_out("flt_hit", 4'h0, 4'h0, 1'b1);
        i_fault_clr = 1'b1;
        tick();
        check_out("flt_clr_active", 4'h0, 4'h0, 1'b1);
        i_fault_clr = 1'b0;
        i_fault     = 1'b0;
        for (int i = 0; i < SYNC_STAGES - 1; i++) begin
            tick();
            check_out($sformatf("flt_drain%0d", i), 4'h0, 4'h0, 1'b1);
        end
        i_fault_clr = 1'b1;
        tick();
        check_out("flt_set_wins", 4'h0, 4'h0, 1'b1);
        tick();
        check_out("flt_cleared", 4'h0, 4'h0, 1'b0);
        i_fault_clr = 1'b0;
        tick();
        check_out("flt_ls_on", 4'h0, 4'hF, 1'b0);
        tick();
        check_out("flt_dtr", 4'h0, 4'h0, 1'b0);
        tick();
        check_out("flt_hs_on", 4'hF, 4'h0, 1'b0);

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        #3;
        i_rst = 1'b1;
        #1;
        check_out("async_rst", 4'h0, 4'h0, 1'b0);
        model_reset();
        #1;
        i_rst = 1'b0;
        i_pwm = 4'h0;
        tick();
        check_out("rst_release", 4'h0, 4'hF, 1'b0);
        model_edge(i_pwm, i_enable, i_dt_rise, i_dt_fall, i_fault, i_fault_clr);

        // Random stimulus against the model, with invariant and dead-time measurements.
        prev_hs = o_hs;
        prev_ls = o_ls;
        f_hold  = 0;
        for (int c = 0; c < NCH; c++) begin
            fall_cyc[c]  = 0;
            fall_need[c] = 1;
        end
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) i_pwm[c] = ~i_pwm[c];
            end
            if ($urandom_range(0, 19) == 0)
                i_dt_rise = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0)
                i_dt_fall = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
            i_enable = ($urandom_range(0, 149) != 0);
            if (f_hold > 0) begin
                i_fault = 1'b1;
                f_hold--;
            end else begin
                i_fault = 1'b0;
                if ($urandom_range(0, 199) == 0) f_hold = int'($urandom_range(1, 10));
            end
            i_fault_clr = ($urandom_range(0, 14) == 0);

            tick();
            model_edge(i_pwm, i_enable, i_dt_rise, i_dt_fall, i_fault, i_fault_clr);
            check("rand hs", 32'(o_hs), 32'(e_hs));
            check("rand ls", 32'(o_ls), 32'(e_ls));
            check("rand fault", 32'(o_fault), 32'(e_fault));
            check("overlap", 32'(o_hs & o_ls), 32'd0);
            for (int c = 0; c < NCH; c++) begin
                if (prev_ls[c] && !o_ls[c] && !o_hs[c]) begin
                    fall_cyc[c]  = cyc;
                    fall_need[c] = (i_dt_rise == '0) ? 1 : int'(i_dt_rise);
                end
                if (!prev_hs[c] && o_hs[c]) begin
                    checks++;
                    if (cyc - fall_cyc[c] < fall_need[c]) begin
                        errors++;
                        $display("FAIL rise_deadtime ch%0d: actual %0d cycles required >= %0d",
                                 c, cyc - fall_cyc[c], fall_need[c]);
                    end
                end
            end
            prev_hs = o_hs;
            prev_ls = o_ls;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
